// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, control-word layout
// and the opcode-to-control decoder.
package id_pkg;

  localparam int CTRL_W = 11;

  localparam int CTRL_REG_DST    = 10;
  localparam int CTRL_JUMP       = 9;
  localparam int CTRL_ALU_SRC    = 8;
  localparam int CTRL_MEM_TO_REG = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_REG_WRITE  = 3;
  localparam int CTRL_ALU_OP_HI  = 2;
  localparam int CTRL_ALU_OP_LO  = 1;
  localparam int CTRL_USES_RT    = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef logic [CTRL_W-1:0] ctrl_t;

  // Field order matches the bit indices above, MSB first.
  typedef struct packed {
    logic       reg_dst;
    logic       jump;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       uses_rt;
  } ctrl_s;

  function automatic ctrl_t ctrl_decode(input logic [5:0] opcode);
    ctrl_s c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = 2'b10; c.uses_rt = 1'b1; end
      OP_LW:    begin c.alu_src = 1'b1; c.mem_to_reg = 1'b1; c.mem_read = 1'b1; c.reg_write = 1'b1; end
      OP_SW:    begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.uses_rt = 1'b1; end
      OP_BEQ:   begin c.branch = 1'b1; c.alu_op = 2'b01; c.uses_rt = 1'b1; end
      OP_J:     begin c.jump = 1'b1; end
      OP_ADDI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
      default:  c = '0;
    endcase
    return ctrl_t'(c);
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file with two operand read ports, a debug read port and one write
// port; reads see a same-cycle write (write-through) and r0 can be hard-zero.
module regfile_bypass #(
  parameter  int DATA_W  = 32,
  parameter  int NREGS   = 32,
  parameter  int R0_ZERO = 1,
  localparam int REG_AW  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic [REG_AW-1:0] rad,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rdd
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic              w_wr_en;

  assign w_wr_en = we && !((R0_ZERO != 0) && (waddr == '0)) && (int'(waddr) < NREGS);

  function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] addr);
    logic [DATA_W-1:0] v;
    v = '0;
    if ((R0_ZERO != 0) && (addr == '0)) v = '0;
    else if (we && (waddr == addr))     v = wdata;
    else if (int'(addr) < NREGS)        v = r_mem[addr];
    return v;
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
    rdd = read_port(rad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// MIPS instruction-decode stage with the ID/EX pipeline register: decode,
// bypassed register read, immediate extension and load-use bubble insertion.
module id_ex_stage
  import id_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int PC_W     = 32,
  parameter  int NREGS    = 32,
  parameter  int SIGN_EXT = 1,
  parameter  int R0_ZERO  = 1,
  localparam int REG_AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [31:0]       if_instr,
  input  logic              hold_in,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [5:0]        ex_func,
  output logic [CTRL_W-1:0] ex_ctrl
);

  function automatic logic signed [DATA_W-1:0] ext_imm(input logic [15:0] imm);
    if (SIGN_EXT != 0) return DATA_W'($signed(imm));
    return DATA_W'(imm);
  endfunction

  logic [REG_AW-1:0]        w_rs, w_rt, w_rd;
  ctrl_t                    w_dec_ctrl;
  logic signed [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0]        w_rs_val, w_rt_val;
  logic                     w_hazard;
  logic                     w_issue;

  logic                     r_vld_p1;
  logic [PC_W-1:0]          r_pc_p1;
  logic [DATA_W-1:0]        r_a_p1, r_b_p1;
  logic signed [DATA_W-1:0] r_imm_p1;
  logic [REG_AW-1:0]        r_rs_p1, r_rt_p1, r_rd_p1;
  logic [5:0]               r_func_p1;
  ctrl_t                    r_ctrl_p1;

  assign w_rs       = if_instr[21 +: REG_AW];
  assign w_rt       = if_instr[16 +: REG_AW];
  assign w_rd       = if_instr[11 +: REG_AW];
  assign w_dec_ctrl = ctrl_decode(if_instr[31:26]);
  assign w_imm      = ext_imm(if_instr[15:0]);

  regfile_bypass #(
    .DATA_W  (DATA_W),
    .NREGS   (NREGS),
    .R0_ZERO (R0_ZERO)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_we),
    .waddr (wb_addr),
    .wdata (wb_data),
    .ra1   (w_rs),
    .ra2   (w_rt),
    .rad   (dbg_addr),
    .rd1   (w_rs_val),
    .rd2   (w_rt_val),
    .rdd   (dbg_data)
  );

  // Load in EX whose destination is a source of the instruction in ID;
  // rt only counts when the decoded instruction actually reads it.
  assign w_hazard = r_vld_p1 & r_ctrl_p1[CTRL_MEM_READ] & (r_rt_p1 != '0) & if_valid &
                    ((r_rt_p1 == w_rs) | ((r_rt_p1 == w_rt) & w_dec_ctrl[CTRL_USES_RT]));

  assign id_stall = ~rst & (hold_in | (w_hazard & ~flush));
  assign w_issue  = if_valid & ~flush & ~w_hazard;

  // ID -> EX boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_ctrl_p1 <= '0;
      r_pc_p1   <= '0;
      r_a_p1    <= '0;
      r_b_p1    <= '0;
      r_imm_p1  <= '0;
      r_rs_p1   <= '0;
      r_rt_p1   <= '0;
      r_rd_p1   <= '0;
      r_func_p1 <= '0;
    end else if (!hold_in) begin
      r_vld_p1  <= w_issue;
      r_ctrl_p1 <= w_issue ? w_dec_ctrl : '0;
      r_pc_p1   <= if_pc;
      r_a_p1    <= w_rs_val;
      r_b_p1    <= w_rt_val;
      r_imm_p1  <= w_imm;
      r_rs_p1   <= w_rs;
      r_rt_p1   <= w_rt;
      r_rd_p1   <= w_rd;
      r_func_p1 <= if_instr[5:0];
    end
  end

  assign ex_valid = r_vld_p1;
  assign ex_ctrl  = r_ctrl_p1;
  assign ex_pc    = r_pc_p1;
  assign ex_a     = r_a_p1;
  assign ex_b     = r_b_p1;
  assign ex_imm   = r_imm_p1;
  assign ex_rs    = r_rs_p1;
  assign ex_rt    = r_rt_p1;
  assign ex_rd    = r_rd_p1;
  assign ex_func  = r_func_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hold/reset sequences, then
// randomized traffic against a behavioural model of the decode stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_valid, hold_in, flush, wb_we;
  logic [31:0] if_pc, if_instr, wb_data;
  logic [4:0]  wb_addr, dbg_addr;

  logic [31:0] dbg_data, ex_pc, ex_a, ex_b, ex_imm;
  logic        id_stall, ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_func;
  logic [10:0] ex_ctrl;

  logic [31:0] z_dbg_data, z_ex_pc, z_ex_a, z_ex_b, z_ex_imm;
  logic        z_id_stall, z_ex_valid;
  logic [4:0]  z_ex_rs, z_ex_rt, z_ex_rd;
  logic [5:0]  z_ex_func;
  logic [10:0] z_ex_ctrl;

  id_ex_stage #(.DATA_W(32), .PC_W(32), .NREGS(32), .SIGN_EXT(1), .R0_ZERO(1)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .hold_in(hold_in), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_func(ex_func), .ex_ctrl(ex_ctrl));

  id_ex_stage #(.DATA_W(32), .PC_W(32), .NREGS(32), .SIGN_EXT(0), .R0_ZERO(1)) dut_z (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .hold_in(hold_in), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(z_dbg_data), .id_stall(z_id_stall), .ex_valid(z_ex_valid),
    .ex_pc(z_ex_pc), .ex_a(z_ex_a), .ex_b(z_ex_b), .ex_imm(z_ex_imm), .ex_rs(z_ex_rs),
    .ex_rt(z_ex_rt), .ex_rd(z_ex_rd), .ex_func(z_ex_func), .ex_ctrl(z_ex_ctrl));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [10:0] m_ctrl;
  logic [31:0] m_pc, m_a, m_b, m_imm, m_immz;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [5:0]  m_func;
  logic        act_stall;
  logic [31:0] act_dbg;

  // {reg_dst,jump,alu_src,mem_to_reg,mem_read,mem_write,branch,reg_write,alu_op,uses_rt}
  function automatic logic [10:0] m_dec(input logic [5:0] op);
    case (op)
      6'h00:   return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
      6'h23:   return {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
      6'h2B:   return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1};
      6'h04:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
      6'h02:   return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      6'h08:   return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
      default: return 11'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return m_rf[a];
  endfunction

  task automatic cycle(input logic r, input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic h, input logic fl, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] da, input bit use_model);
    logic [10:0] dec;
    logic        haz, e_stall;
    logic [4:0]  rs, rt;
    logic [31:0] a, b, e_dbg;
    rst = r; if_valid = iv; if_instr = ins; if_pc = pc; hold_in = h; flush = fl;
    wb_we = we; wb_addr = wa; wb_data = wd; dbg_addr = da;
    rs  = ins[25:21];
    rt  = ins[20:16];
    dec = m_dec(ins[31:26]);
    haz = m_valid && m_ctrl[6] && (m_rt != 5'd0) && iv && ((m_rt == rs) || ((m_rt == rt) && dec[0]));
    e_stall = !r && (h || (haz && !fl));
    e_dbg   = m_read(da, we, wa, wd);
    a = m_read(rs, we, wa, wd);
    b = m_read(rt, we, wa, wd);
    #3;
    act_stall = id_stall;
    act_dbg   = dbg_data;
    if (use_model) begin
      chk("rnd_stall", {63'h0, id_stall}, {63'h0, e_stall});
      chk("rnd_dbg", {32'h0, dbg_data}, {32'h0, e_dbg});
      chk("rnd_z_stall", {63'h0, z_id_stall}, {63'h0, e_stall});
      chk("rnd_z_dbg", {32'h0, z_dbg_data}, {32'h0, e_dbg});
    end
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_a = '0; m_b = '0; m_imm = '0; m_immz = '0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_func = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    end else begin
      if (!h) begin
        m_valid = iv && !fl && !haz;
        m_ctrl  = m_valid ? dec : 11'h0;
        m_pc = pc; m_a = a; m_b = b;
        m_imm  = {{16{ins[15]}}, ins[15:0]};
        m_immz = {16'h0, ins[15:0]};
        m_rs = rs; m_rt = rt; m_rd = ins[15:11]; m_func = ins[5:0];
      end
      if (we && wa != 5'd0) m_rf[wa] = wd;
    end
    #1;
    if (use_model) begin
      chk("rnd_valid", {63'h0, ex_valid}, {63'h0, m_valid});
      chk("rnd_ctrl", {53'h0, ex_ctrl}, {53'h0, m_ctrl});
      chk("rnd_pc", {32'h0, ex_pc}, {32'h0, m_pc});
      chk("rnd_a", {32'h0, ex_a}, {32'h0, m_a});
      chk("rnd_b", {32'h0, ex_b}, {32'h0, m_b});
      chk("rnd_imm", {32'h0, ex_imm}, {32'h0, m_imm});
      chk("rnd_fields", {43'h0, ex_rs, ex_rt, ex_rd, ex_func}, {43'h0, m_rs, m_rt, m_rd, m_func});
      chk("rnd_z_imm", {32'h0, z_ex_imm}, {32'h0, m_immz});
      chk("rnd_z_ctl", {11'h0, z_ex_valid, z_ex_ctrl, z_ex_pc, z_ex_rs, z_ex_rt, z_ex_rd, z_ex_func},
                       {11'h0, m_valid, m_ctrl, m_pc, m_rs, m_rt, m_rd, m_func});
      chk("rnd_z_ab", {z_ex_a, z_ex_b}, {m_a, m_b});
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, iv;
    logic [31:0] instr;
    logic        hold, flush, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  da;
    logic        exp_stall;
    logic [31:0] exp_dbg;
    logic        exp_valid;
    logic [10:0] exp_ctrl;
    logic [31:0] exp_a, exp_b, exp_imm, exp_immz;
  } vec_t;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  vec_t        tbl [22];
  vec_t        v;
  logic [31:0] ADD356, ADD241, LW4, LW7, LW0, SW27, SW00, ADDI, ADDI27, BEQ, JMP, UNK;

  initial begin
    ADD356 = enc_r(5'd5, 5'd6, 5'd3, 6'h20);
    ADD241 = enc_r(5'd4, 5'd1, 5'd2, 6'h20);
    LW4    = enc_i(6'h23, 5'd1, 5'd4, 16'h0008);
    LW7    = enc_i(6'h23, 5'd1, 5'd7, 16'h0000);
    LW0    = enc_i(6'h23, 5'd1, 5'd0, 16'h0000);
    SW27   = enc_i(6'h2B, 5'd2, 5'd7, 16'h0004);
    SW00   = enc_i(6'h2B, 5'd0, 5'd0, 16'h0004);
    ADDI   = enc_i(6'h08, 5'd0, 5'd9, 16'h8000);
    ADDI27 = enc_i(6'h08, 5'd2, 5'd7, 16'h0001);
    BEQ    = enc_i(6'h04, 5'd3, 5'd5, 16'hFFFE);
    JMP    = {6'h02, 26'h0000010};
    UNK    = {6'h3F, 26'h0};

    //         rst iv instr  hold flush we  wa     wd          da     stall dbg        valid ctrl    a           b           imm           immz
    tbl[0]  = '{Y, N, 32'h0, N, N, N, 5'd0, 32'h0,      5'd0, N, 32'h0,      N, 11'h000, 32'h0,      32'h0,      32'h0,        32'h0};
    tbl[1]  = '{N, N, 32'h0, N, N, N, 5'd0, 32'h0,      5'd0, N, 32'h0,      N, 11'h000, 32'h0,      32'h0,      32'h0,        32'h0};
    tbl[2]  = '{N, Y, ADD356, N, N, Y, 5'd5, 32'h1234,  5'd5, N, 32'h1234,   Y, 11'h40D, 32'h1234,   32'h0,      32'h1820,     32'h1820};
    tbl[3]  = '{N, N, 32'h0, N, N, Y, 5'd0, 32'hFFFF,   5'd0, N, 32'h0,      N, 11'h000, 32'h0,      32'h0,      32'h0,        32'h0};
    tbl[4]  = '{N, N, 32'h0, N, N, N, 5'd0, 32'h0,      5'd0, N, 32'h0,      N, 11'h000, 32'h0,      32'h0,      32'h0,        32'h0};
    tbl[5]  = '{N, N, 32'h0, N, N, Y, 5'd1, 32'h11,     5'd1, N, 32'h11,     N, 11'h000, 32'h0,      32'h0,      32'h0,        32'h0};
    tbl[6]  = '{N, Y, LW4,   N, N, N, 5'd0, 32'h0,      5'd5, N, 32'h1234,   Y, 11'h1C8, 32'h11,     32'h0,      32'h8,        32'h8};
    tbl[7]  = '{N, Y, ADD241, N, N, Y, 5'd4, 32'hABCD,  5'd4, Y, 32'hABCD,   N, 11'h000, 32'hABCD,   32'h11,     32'h1020,     32'h1020};
    tbl[8]  = '{N, Y, ADD241, N, N, N, 5'd0, 32'h0,     5'd4, N, 32'hABCD,   Y, 11'h40D, 32'hABCD,   32'h11,     32'h1020,     32'h1020};
    tbl[9]  = '{N, Y, LW4,   N, N, N, 5'd0, 32'h0,      5'd0, N, 32'h0,      Y, 11'h1C8, 32'h11,     32'hABCD,   32'h8,        32'h8};
    tbl[10] = '{N, Y, ADD241, N, Y, N, 5'd0, 32'h0,     5'd0, N, 32'h0,      N, 11'h000, 32'hABCD,   32'h11,     32'h1020,     32'h1020};
    tbl[11] = '{N, Y, ADDI,  N, N, N, 5'd0, 32'h0,      5'd0, N, 32'h0,      Y, 11'h108, 32'h0,      32'h0,      32'hFFFF8000, 32'h8000};
    tbl[12] = '{N, Y, UNK,   N, N, N, 5'd0, 32'h0,      5'd0, N, 32'h0,      Y, 11'h000, 32'h0,      32'h0,      32'h0,        32'h0};
    tbl[13] = '{N, Y, LW7,   N, N, N, 5'd0, 32'h0,      5'd0, N, 32'h0,      Y, 11'h1C8, 32'h11,     32'h0,      32'h0,        32'h0};
    tbl[14] = '{N, Y, SW27,  N, N, N, 5'd0, 32'h0,      5'd0, Y, 32'h0,      N, 11'h000, 32'h0,      32'h0,      32'h4,        32'h4};
    tbl[15] = '{N, Y, SW27,  N, N, N, 5'd0, 32'h0,      5'd0, N, 32'h0,      Y, 11'h121, 32'h0,      32'h0,      32'h4,        32'h4};
    tbl[16] = '{N, Y, LW0,   N, N, N, 5'd0, 32'h0,      5'd0, N, 32'h0,      Y, 11'h1C8, 32'h11,     32'h0,      32'h0,        32'h0};
    tbl[17] = '{N, Y, SW00,  N, N, N, 5'd0, 32'h0,      5'd0, N, 32'h0,      Y, 11'h121, 32'h0,      32'h0,      32'h4,        32'h4};
    tbl[18] = '{N, Y, LW7,   N, N, N, 5'd0, 32'h0,      5'd0, N, 32'h0,      Y, 11'h1C8, 32'h11,     32'h0,      32'h0,        32'h0};
    tbl[19] = '{N, Y, ADDI27, N, N, N, 5'd0, 32'h0,     5'd0, N, 32'h0,      Y, 11'h108, 32'h0,      32'h0,      32'h1,        32'h1};
    tbl[20] = '{N, Y, BEQ,   N, N, N, 5'd0, 32'h0,      5'd0, N, 32'h0,      Y, 11'h013, 32'h0,      32'h1234,   32'hFFFFFFFE, 32'hFFFE};
    tbl[21] = '{N, Y, JMP,   N, N, N, 5'd0, 32'h0,      5'd0, N, 32'h0,      Y, 11'h200, 32'h0,      32'h0,      32'h10,       32'h10};

    for (int i = 0; i < 22; i++) begin
      v = tbl[i];
      cycle(v.rst, v.iv, v.instr, 32'(32'h100 + 4 * i), v.hold, v.flush, v.we, v.wa, v.wd, v.da, 1'b0);
      chk($sformatf("tbl%0d_stall", i), {63'h0, act_stall}, {63'h0, v.exp_stall});
      chk($sformatf("tbl%0d_dbg", i), {32'h0, act_dbg}, {32'h0, v.exp_dbg});
      chk($sformatf("tbl%0d_valid", i), {63'h0, ex_valid}, {63'h0, v.exp_valid});
      chk($sformatf("tbl%0d_ctrl", i), {53'h0, ex_ctrl}, {53'h0, v.exp_ctrl});
      chk($sformatf("tbl%0d_ab", i), {ex_a, ex_b}, {v.exp_a, v.exp_b});
      chk($sformatf("tbl%0d_imm", i), {32'h0, ex_imm}, {32'h0, v.exp_imm});
      chk($sformatf("tbl%0d_immz", i), {32'h0, z_ex_imm}, {32'h0, v.exp_immz});
      chk($sformatf("tbl%0d_pc", i), {32'h0, ex_pc}, v.rst ? 64'h0 : 64'(32'h100 + 4 * i));
    end

    // Hold for three cycles with a write-back underway: EX frozen on the jump.
    for (int k = 0; k < 3; k++) begin
      cycle(N, Y, ADD356, 32'h200, Y, N, (k == 0), 5'd9, 32'h55, 5'd9, 1'b0);
      chk($sformatf("hold%0d_stall", k), {63'h0, act_stall}, 64'h1);
      chk($sformatf("hold%0d_dbg", k), {32'h0, act_dbg}, 64'h55);
      chk($sformatf("hold%0d_ex", k), {ex_valid, ex_ctrl, ex_pc, ex_imm[19:0]}, {1'b1, 11'h200, 32'h154, 20'h10});
    end
    cycle(N, Y, ADD356, 32'h200, N, N, N, 5'd0, 32'h0, 5'd9, 1'b0);
    chk("release_stall", {63'h0, act_stall}, 64'h0);
    chk("release_ex", {ex_valid, ex_ctrl, ex_pc, ex_a[19:0]}, {1'b1, 11'h40D, 32'h200, 20'h01234});

    // Reset mid-stream with hold asserted: stall suppressed, EX and regfile cleared.
    cycle(Y, Y, ADD356, 32'h204, Y, N, N, 5'd0, 32'h0, 5'd5, 1'b0);
    chk("rst_stall", {63'h0, act_stall}, 64'h0);
    chk("rst_ex", {ex_valid, ex_ctrl, ex_pc, ex_a[19:0]}, 64'h0);
    cycle(N, N, 32'h0, 32'h0, N, N, N, 5'd0, 32'h0, 5'd5, 1'b0);
    chk("rst_rf_cleared", {32'h0, act_dbg}, 64'h0);

    // Randomized traffic against the model; small register range provokes hazards.
    for (int n = 0; n < 500; n++) begin
      logic [5:0]  op;
      logic [31:0] ins;
      case ($urandom_range(0, 7))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h02;
        5: op = 6'h08;
        default: op = 6'($urandom);
      endcase
      ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), ins, $urandom,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
            5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
